mux_2_1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 2:1 mux datapath. It lets two requesters share one downstream output channel. It owns the mux select, grants the channel to one requester at a time under a valid/ready handshake, and holds the grant for a whole burst (up to `last`). A burst-length cap forces a handoff when the other requester is waiting.

---
 rtl/mux_2_1_arbiter_if.sv | 43 ++++
 rtl/mux_2_1_arbiter.sv | 111 +++++++++++
 tb/tb_mux_2_1_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mux_2_1_arbiter_if.sv
// rtl/mux_2_1_arbiter_if.sv - requester/output bundle for the 2:1 round-robin arbiter
interface mux_2_1_arbiter_if #(
  parameter int W = 8
);
  // requester 0
  logic         req0;
  logic [W-1:0] data0;
  logic         last0;
  logic         gnt0;
  // requester 1
  logic         req1;
  logic [W-1:0] data1;
  logic         last1;
  logic         gnt1;
  // downstream channel
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_last;
  logic         y_ready;
  // status
  logic         sel;
  logic         busy;

  // arbiter side
  modport slave (
    input  req0, data0, last0,
    input  req1, data1, last1,
    input  y_ready,
    output gnt0, gnt1,
    output y_valid, y_data, y_last,
    output sel, busy
  );

  // requester/downstream side
  modport master (
    output req0, data0, last0,
    output req1, data1, last1,
    output y_ready,
    input  gnt0, gnt1,
    input  y_valid, y_data, y_last,
    input  sel, busy
  );
endinterface

// File: rtl/mux_2_1_arbiter.sv
// rtl/mux_2_1_arbiter.sv - round-robin burst arbiter owning the shared 2:1 mux select
module mux_2_1_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_2_1_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  // last beat index allowed before a waiting requester forces a handoff
  localparam logic [7:0] CAP = 8'(MAX_BURST - 1);

  logic [1:0]   state, state_nxt;
  logic         prio, prio_nxt;
  logic         sel, sel_nxt;
  logic [7:0]   cnt, cnt_nxt;

  logic         own0, own1, owning;
  logic         own_req, own_last, other_req, other_id;
  logic         beat, at_cap, release_now;
  logic [W-1:0] y_mux;

  // decode the current owner and what its beat means for the grant
  always_comb begin
    own0        = (state == OWN0);
    own1        = (state == OWN1);
    owning      = own0 | own1;
    own_req     = own1 ? bus.req1  : bus.req0;
    own_last    = own1 ? bus.last1 : bus.last0;
    other_req   = own1 ? bus.req0  : bus.req1;
    other_id    = ~own1;
    beat        = owning && own_req && bus.y_ready;
    at_cap      = (cnt == CAP);
    // last and cap on the same beat collapse into one release
    release_now = beat && (own_last || (at_cap && other_req));
  end

  // next-state arbitration, burst counting and handoff
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || !prio)) begin
          state_nxt = OWN0;
          sel_nxt   = 1'b0;
          cnt_nxt   = 8'd0;
        end else if (bus.req1) begin
          state_nxt = OWN1;
          sel_nxt   = 1'b1;
          cnt_nxt   = 8'd0;
        end
      end
      OWN0, OWN1: begin
        if (release_now) begin
          prio_nxt = other_id;
          cnt_nxt  = 8'd0;
          if (other_req) begin
            // hand straight over, no idle bubble between bursts
            state_nxt = other_id ? OWN1 : OWN0;
            sel_nxt   = other_id;
          end else begin
            // sel holds so the mux stays on the last owner while idle
            state_nxt = IDLE;
          end
        end else if (beat && !at_cap) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state registers; reset abandons any in-flight burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      sel   <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // datapath mux is purely combinational from the registered select
  always_comb begin
    y_mux = sel ? bus.data1 : bus.data0;
  end

  assign bus.y_data  = y_mux;
  assign bus.y_last  = sel ? bus.last1 : bus.last0;
  assign bus.y_valid = owning && own_req;
  assign bus.gnt0    = own0 && bus.y_ready;
  assign bus.gnt1    = own1 && bus.y_ready;
  assign bus.sel     = sel;
  assign bus.busy    = owning;

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// tb/tb_mux_2_1_arbiter.sv - directed vector bench for mux_2_1_arbiter
module tb_mux_2_1_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_2_1_arbiter_if #(.W(8)) bus ();

  mux_2_1_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       r0, r1, l0, l1, rdy;
    logic [7:0] d0, d1;
    logic       g0, g1, v;
    logic [7:0] yd;
    logic       yl, sel, busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r0, logic r1, logic l0, logic l1, logic rdy,
                              logic [7:0] d0, logic [7:0] d1,
                              logic g0, logic g1, logic v, logic [7:0] yd,
                              logic yl, logic sel, logic busy);
    vec_t t;
    t.r0 = r0; t.r1 = r1; t.l0 = l0; t.l1 = l1; t.rdy = rdy;
    t.d0 = d0; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.v = v; t.yd = yd;
    t.yl = yl; t.sel = sel; t.busy = busy;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r0, logic r1, logic l0, logic l1, logic rdy,
                       logic [7:0] d0, logic [7:0] d1);
    bus.req0 = r0; bus.req1 = r1; bus.last0 = l0; bus.last1 = l1;
    bus.y_ready = rdy; bus.data0 = d0; bus.data1 = d1;
  endtask

  initial begin
    // reset and idle
    vq.push_back(mk(0,0,0,0,1,8'hA5,8'h5A, 0,0,0,8'hA5,0,0,0));
    vq.push_back(mk(0,0,1,0,1,8'hA5,8'h5A, 0,0,0,8'hA5,1,0,0));
    vq.push_back(mk(0,0,0,1,1,8'hA5,8'h5A, 0,0,0,8'hA5,0,0,0));
    // simultaneous start, prio 0 wins, zero-gap handoff
    vq.push_back(mk(1,1,0,0,1,8'h01,8'h81, 0,0,0,8'h01,0,0,0));
    vq.push_back(mk(1,1,0,0,1,8'h01,8'h81, 1,0,1,8'h01,0,0,1));
    vq.push_back(mk(1,1,1,0,1,8'h02,8'h81, 1,0,1,8'h02,1,0,1));
    vq.push_back(mk(0,1,0,0,1,8'h02,8'h81, 0,1,1,8'h81,0,1,1));
    vq.push_back(mk(0,1,0,1,1,8'h02,8'h82, 0,1,1,8'h82,1,1,1));
    vq.push_back(mk(0,0,0,0,1,8'h00,8'h99, 0,0,0,8'h99,0,1,0));
    // single 3-beat burst from requester 0
    vq.push_back(mk(1,0,0,0,1,8'h11,8'h99, 0,0,0,8'h99,0,1,0));
    vq.push_back(mk(1,0,0,0,1,8'h11,8'h99, 1,0,1,8'h11,0,0,1));
    vq.push_back(mk(1,0,0,0,1,8'h22,8'h99, 1,0,1,8'h22,0,0,1));
    vq.push_back(mk(1,0,1,0,1,8'h33,8'h99, 1,0,1,8'h33,1,0,1));
    vq.push_back(mk(0,0,0,0,1,8'h00,8'h99, 0,0,0,8'h00,0,0,0));
    // burst cap: forced handoff after 4 beats, then re-grant
    vq.push_back(mk(1,0,0,0,1,8'hA0,8'hB0, 0,0,0,8'hA0,0,0,0));
    vq.push_back(mk(1,1,0,0,1,8'hA0,8'hB0, 1,0,1,8'hA0,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hA1,8'hB0, 1,0,1,8'hA1,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hA2,8'hB0, 1,0,1,8'hA2,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hA3,8'hB0, 1,0,1,8'hA3,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hA4,8'hB0, 0,1,1,8'hB0,0,1,1));
    vq.push_back(mk(1,1,0,1,1,8'hA4,8'hB1, 0,1,1,8'hB1,1,1,1));
    vq.push_back(mk(1,0,0,0,1,8'hA4,8'hB1, 1,0,1,8'hA4,0,0,1));
    // saturated counter keeps streaming, first other request forces release
    vq.push_back(mk(1,0,0,0,1,8'hA5,8'hB1, 1,0,1,8'hA5,0,0,1));
    vq.push_back(mk(1,0,0,0,1,8'hA6,8'hB1, 1,0,1,8'hA6,0,0,1));
    vq.push_back(mk(1,0,0,0,1,8'hA7,8'hB1, 1,0,1,8'hA7,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hA8,8'hC0, 1,0,1,8'hA8,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hA9,8'hC0, 0,1,1,8'hC0,0,1,1));
    vq.push_back(mk(0,1,0,1,1,8'hA9,8'hC1, 0,1,1,8'hC1,1,1,1));
    vq.push_back(mk(0,0,0,0,1,8'h00,8'hC2, 0,0,0,8'hC2,0,1,0));
    // last coinciding with cap is one release
    vq.push_back(mk(1,0,0,0,1,8'hD0,8'hE0, 0,0,0,8'hE0,0,1,0));
    vq.push_back(mk(1,1,0,0,1,8'hD0,8'hE0, 1,0,1,8'hD0,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hD1,8'hE0, 1,0,1,8'hD1,0,0,1));
    vq.push_back(mk(1,1,0,0,1,8'hD2,8'hE0, 1,0,1,8'hD2,0,0,1));
    vq.push_back(mk(1,1,1,0,1,8'hD3,8'hE0, 1,0,1,8'hD3,1,0,1));
    vq.push_back(mk(0,1,0,1,1,8'hD3,8'hE0, 0,1,1,8'hE0,1,1,1));
    vq.push_back(mk(0,0,0,0,1,8'h00,8'hE1, 0,0,0,8'hE1,0,1,0));

    // reset held low with no requests
    drive(0,0,0,0,1,8'h00,8'h00);
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    chk("rst_valid", 32'(bus.y_valid), 32'd0);
    chk("rst_prio_cnt", {23'd0, dut.prio, dut.cnt}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_%0d", i), {28'd0, bus.busy, bus.sel, bus.gnt0, bus.gnt1}, 32'd0);
    end

    foreach (vq[i]) begin
      drive(vq[i].r0, vq[i].r1, vq[i].l0, vq[i].l1, vq[i].rdy, vq[i].d0, vq[i].d1);
      #4;
      chk($sformatf("vec_%0d", i),
          {17'd0, bus.gnt0, bus.gnt1, bus.y_valid, bus.y_data, bus.y_last, bus.sel, bus.busy},
          {17'd0, vq[i].g0, vq[i].g1, vq[i].v, vq[i].yd, vq[i].yl, vq[i].sel, vq[i].busy});
      tick();
    end
    chk("prio_after_table", 32'(dut.prio), 32'd0);

    // backpressure and held grant
    drive(1,0,0,0,1,8'hF0,8'h0F);
    tick();
    chk("bp_own0", {30'd0, bus.busy, bus.sel}, 32'h2);
    chk("bp_first_gnt", 32'(bus.gnt0), 32'd1);
    tick();
    chk("bp_cnt_start", 32'(dut.cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1,1,0,0,0,8'hF1,8'h0F);
      #1;
      chk($sformatf("bp_stall_%0d", i), {29'd0, bus.gnt0, bus.gnt1, bus.y_valid}, 32'h1);
      tick();
      chk($sformatf("bp_cnt_%0d", i), 32'(dut.cnt), 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0,1,0,0,1,8'hF1,8'h0F);
      #1;
      chk($sformatf("hold_%0d", i), {28'd0, bus.gnt0, bus.gnt1, bus.y_valid, bus.busy}, 32'h9);
      tick();
      chk($sformatf("hold_st_%0d", i), {23'd0, bus.sel, dut.cnt}, 32'd1);
    end
    drive(1,1,1,0,1,8'hF2,8'h0F);
    tick();
    drive(0,1,0,0,1,8'hF2,8'h0F);
    #1;
    chk("handoff_own1", {29'd0, bus.sel, bus.gnt0, bus.gnt1}, 32'h5);

    // asynchronous reset mid-burst in OWN1
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {27'd0, bus.busy, bus.sel, bus.gnt0, bus.gnt1, bus.y_valid}, 32'd0);
    chk("arst_prio", 32'(dut.prio), 32'd0);
    tick();
    drive(1,1,0,0,1,8'h44,8'h55);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_idle", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    tick();
    chk("arst_regrant", {28'd0, bus.busy, bus.sel, bus.gnt0, bus.gnt1}, 32'hA);
    chk("arst_data", 32'(bus.y_data), 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
